// File: rtl/uart_mode_ctrl.sv
// Switch synchroniser/debouncer plus CFG/PEND/RUN mode FSM selecting the UART baud index and data direction.
// Build macro UART_MODE_DEBOUNCE_EN enables the per-bit debouncers; without it the synchroniser output is used directly.
module uart_mode_ctrl #(
    parameter int SW_W       = 10,
    parameter int BAUD_W     = 2,
    parameter int DEB_CYCLES = 16,
    parameter int BAUD_RESET = 1
) (
    input  logic              src_clk,
    input  logic              rst_n,
    input  logic [SW_W-1:0]   Switches,
    input  logic              uart_busy,
    output logic [BAUD_W-1:0] baud_sel,
    output logic              baud_update,
    output logic              data_dir,
    output logic              mode,
    output logic              pending
);

    if (SW_W <= BAUD_W) begin : gBadSwW
        $error("uart_mode_ctrl: SW_W must be greater than BAUD_W");
    end
    if (DEB_CYCLES < 2) begin : gBadDeb
        $error("uart_mode_ctrl: DEB_CYCLES must be at least 2");
    end
    if (BAUD_RESET < 0 || BAUD_RESET >= (1 << BAUD_W)) begin : gBadBaud
        $error("uart_mode_ctrl: BAUD_RESET does not fit in BAUD_W bits");
    end

    typedef enum logic [1:0] {
        CFG  = 2'd0,
        PEND = 2'd1,
        RUN  = 2'd2
    } stateE;

    logic [SW_W-1:0]   swMeta;
    logic [SW_W-1:0]   swSync;
    logic [SW_W-1:0]   swDeb;
    logic [BAUD_W-1:0] req;
    logic [BAUD_W-1:0] baudNext;
    logic              updNext;
    logic              dirNext;
    stateE             state;
    stateE             stateNext;

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            swMeta <= '0;
            swSync <= '0;
        end else begin
            swMeta <= Switches;
            swSync <= swMeta;
        end
    end

`ifdef UART_MODE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES);

    // Each bit flips only after DEB_CYCLES consecutive samples disagree with it.
    for (genvar i = 0; i < SW_W; i++) begin : gDeb
        logic             stable;
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge src_clk or negedge rst_n) begin
            if (!rst_n) begin
                stable <= 1'b0;
                cnt    <= '0;
            end else if (swSync[i] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign swDeb[i] = stable;
    end
`else
    assign swDeb = swSync;
`endif

    if (SW_W > BAUD_W + 1) begin : gUnused
        logic unusedSw;
        assign unusedSw = ^swDeb[SW_W-1:BAUD_W+1];
    end

    assign req = swDeb[BAUD_W:1];

    // SW[0] going high always wins over a baud change in the same cycle.
    always_comb begin
        stateNext = state;
        baudNext  = baud_sel;
        updNext   = 1'b0;
        unique case (state)
            CFG: begin
                if (swDeb[0]) begin
                    stateNext = RUN;
                end else if (req != baud_sel) begin
                    if (uart_busy) begin
                        stateNext = PEND;
                    end else begin
                        baudNext = req;
                        updNext  = 1'b1;
                    end
                end
            end
            PEND: begin
                if (swDeb[0]) begin
                    stateNext = RUN;
                end else if (req == baud_sel) begin
                    stateNext = CFG;
                end else if (!uart_busy) begin
                    baudNext  = req;
                    updNext   = 1'b1;
                    stateNext = CFG;
                end
            end
            RUN: begin
                if (!swDeb[0]) begin
                    stateNext = CFG;
                end
            end
            default: stateNext = CFG;
        endcase
        dirNext = (stateNext == RUN) ? swDeb[1] : 1'b0;
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CFG;
            baud_sel    <= BAUD_W'(BAUD_RESET);
            baud_update <= 1'b0;
            data_dir    <= 1'b0;
        end else begin
            state       <= stateNext;
            baud_sel    <= baudNext;
            baud_update <= updNext;
            data_dir    <= dirNext;
        end
    end

    assign mode    = (state == RUN);
    assign pending = (state == PEND);

endmodule
